// File: rtl/ext_bus_video_frame_reader.sv
// Read-only bus initiator: fetches one RGB565 frame, one pixel per bridge read,
// and streams the pixels out on a valid/ready port with start/end-of-frame markers.
module ext_bus_video_frame_reader #(
  parameter logic [29:0] BASE_ADDR = 30'h0200_0000,
  parameter int          H_RES     = 320,
  parameter int          V_RES     = 240,
  parameter int          Y_SHIFT   = 10,
  parameter int          TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [29:0] bus_address,
  output logic [1:0]  bus_byte_enable,
  output logic        bus_read,
  output logic        bus_write,
  output logic [15:0] bus_write_data,
  input  logic        bus_acknowledge,
  input  logic [15:0] bus_read_data,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_sop,
  output logic        pix_eop
);

  typedef enum logic [1:0] {IDLE, REQ, PUSH, DONE} state_t;

  localparam logic [8:0]  X_LAST = 9'(H_RES - 1);
  localparam logic [7:0]  Y_LAST = 8'(V_RES - 1);
  localparam logic [15:0] T_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [8:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [15:0] timer_q, timer_d;
  logic        err_q, err_d;
  logic [15:0] data_q, data_d;

  logic        last_pix;
  logic [29:0] pix_addr;

  assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);
  assign pix_addr = BASE_ADDR + (30'(y_q) << Y_SHIFT) + 30'({x_q, 1'b0});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  // The timer holds the count of REQ cycles already spent; an ack on the last
  // allowed cycle takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    timer_d = timer_q;
    err_d   = err_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = '0;
          y_d     = '0;
          timer_d = '0;
          err_d   = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus_acknowledge) begin
          data_d  = bus_read_data;
          state_d = PUSH;
        end else if (timer_q == T_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      PUSH: begin
        if (pix_ready) begin
          timer_d = '0;
          if (last_pix) begin
            state_d = DONE;
          end else begin
            state_d = REQ;
            if (x_q == X_LAST) begin
              x_d = '0;
              y_d = y_q + 8'd1;
            end else begin
              x_d = x_q + 9'd1;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All outputs decode straight from registers, so reset clears them at once.
  assign bus_read        = (state_q == REQ);
  assign bus_address     = bus_read ? pix_addr : '0;
  assign bus_byte_enable = bus_read ? 2'b11 : 2'b00;
  assign bus_write       = 1'b0;
  assign bus_write_data  = '0;
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);
  assign timeout_err     = err_q;
  assign pix_valid       = (state_q == PUSH);
  assign pix_data        = data_q;
  assign pix_sop         = pix_valid && (x_q == '0) && (y_q == '0);
  assign pix_eop         = pix_valid && last_pix;

endmodule

// File: tb/tb_ext_bus_video_frame_reader.sv
// Scoreboard bench: a bus responder and a pixel sink run independently, with
// expected reads and pixels derived from the frame address formula.
module tb_ext_bus_video_frame_reader;

  localparam logic [29:0] BASE   = 30'h0200_0000;
  localparam int          HRES   = 4;
  localparam int          VRES   = 2;
  localparam int          YSHIFT = 10;
  localparam int          TMO    = 8;
  localparam int          NPIX   = HRES * VRES;

  typedef struct {
    logic [29:0] addr;
    logic        sop;
    logic        eop;
    int          lat;
    logic [15:0] data;
  } reqT;

  typedef struct {
    logic [15:0] data;
    logic        sop;
    logic        eop;
  } pixT;

  logic        clk = 1'b0;
  logic        resetN;
  logic        start;
  logic        busy, done, timeoutErr;
  logic [29:0] busAddress;
  logic [1:0]  busByteEnable;
  logic        busRead, busWrite;
  logic [15:0] busWriteData;
  logic        busAck;
  logic [15:0] busData;
  logic [15:0] pixData;
  logic        pixValid, pixReady, pixSop, pixEop;

  int  compared = 0;
  int  mismatched = 0;
  reqT reqQ[$];
  pixT pixQ[$];
  int  stallCfg = 0;
  bit  randomReady = 0;
  int  pixCount = 0;

  always #5 clk = ~clk;

  ext_bus_video_frame_reader #(
    .BASE_ADDR(BASE), .H_RES(HRES), .V_RES(VRES), .Y_SHIFT(YSHIFT), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset_n(resetN), .start(start), .busy(busy), .done(done),
    .timeout_err(timeoutErr), .bus_address(busAddress), .bus_byte_enable(busByteEnable),
    .bus_read(busRead), .bus_write(busWrite), .bus_write_data(busWriteData),
    .bus_acknowledge(busAck), .bus_read_data(busData), .pix_data(pixData),
    .pix_valid(pixValid), .pix_ready(pixReady), .pix_sop(pixSop), .pix_eop(pixEop)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus responder: acks each read after its scheduled latency, or never when
  // the latency is 0, and throws in stray acks while no read is pending.
  reqT cur;
  bit  active = 0;
  bit  ackReal = 0;
  int  waitCnt = 0;

  always @(negedge clk) begin
    if (!resetN) begin
      busAck  = 1'b0;
      ackReal = 1'b0;
      active  = 1'b0;
    end else begin
      if (busAck) begin
        busAck = 1'b0;
        if (ackReal) begin
          active  = 1'b0;
          ackReal = 1'b0;
        end
      end
      if (busRead) begin
        if (!active) begin
          active  = 1'b1;
          waitCnt = 0;
          checkOutput("read expected", 32'(reqQ.size() > 0), 1);
          if (reqQ.size() > 0) begin
            cur = reqQ.pop_front();
            checkOutput("read address", busAddress, cur.addr);
          end else begin
            cur.addr = busAddress;
            cur.lat  = 0;
          end
          checkOutput("byte enable", busByteEnable, 2'b11);
        end else begin
          checkOutput("address stable", busAddress, cur.addr);
        end
        waitCnt++;
        if (cur.lat != 0 && waitCnt == cur.lat) begin
          busAck  = 1'b1;
          ackReal = 1'b1;
          busData = cur.data;
          pixQ.push_back('{data: cur.data, sop: cur.sop, eop: cur.eop});
        end
      end else if (active) begin
        checkOutput("timeout length", waitCnt, TMO);
        active = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        busAck  = 1'b1;
        busData = 16'($urandom);
      end
    end
  end

  // Pixel sink and monitor: compares every handshake against the scoreboard.
  int          stallCnt = 0;
  bit          prevStall = 0;
  logic [15:0] prevData;
  logic        prevSop, prevEop;
  pixT         expPix;

  always @(negedge clk) begin
    if (!resetN) begin
      pixReady  = 1'b0;
      stallCnt  = 0;
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("valid held", pixValid, 1);
        checkOutput("pixel held", {pixSop, pixEop, pixData}, {prevSop, prevEop, prevData});
      end
      if (pixValid) begin
        if (stallCnt < stallCfg) begin
          pixReady = 1'b0;
          stallCnt++;
        end else begin
          pixReady = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
        end
      end else begin
        pixReady = 1'($urandom_range(0, 1));
      end
      if (pixValid && pixReady) begin
        checkOutput("pixel expected", 32'(pixQ.size() > 0), 1);
        if (pixQ.size() > 0) begin
          expPix = pixQ.pop_front();
          checkOutput("pixel data", pixData, expPix.data);
          checkOutput("sop/eop", {pixSop, pixEop}, {expPix.sop, expPix.eop});
        end
        checkOutput("single outstanding", busRead, 0);
        checkOutput("write idle", {busWrite, busWriteData}, 0);
        pixCount++;
        stallCnt  = 0;
        prevStall = 1'b0;
      end else if (pixValid) begin
        prevStall = 1'b1;
        prevData  = pixData;
        prevSop   = pixSop;
        prevEop   = pixEop;
      end else begin
        prevStall = 1'b0;
      end
    end
  end

  task automatic buildFrame(input int mode, input int withhold);
    reqT e;
    for (int k = 0; k < NPIX; k++) begin
      e.addr = BASE + 30'((k / HRES) * (1 << YSHIFT)) + 30'((k % HRES) * 2);
      e.sop  = (k == 0);
      e.eop  = (k == NPIX - 1);
      e.data = 16'($urandom);
      case (mode)
        0:       e.lat = 1;
        1:       e.lat = 5;
        3:       e.lat = (k == 1) ? TMO : $urandom_range(1, TMO);
        default: e.lat = $urandom_range(1, TMO);
      endcase
      if (mode == 3 && k == 0) e.data = 16'hF800;
      if (mode == 3 && k == 1) e.data = 16'h07E0;
      if (k == withhold) e.lat = 0;
      reqQ.push_back(e);
    end
  endtask

  task automatic applyStimulus(input int mode);
    int withhold = -1;
    int startCount;
    bit expErr;
    bit seenDone = 0;
    if (mode == 2) withhold = 2;
    else if (mode >= 4 && $urandom_range(0, 3) == 0) withhold = $urandom_range(0, NPIX - 1);
    expErr      = (withhold >= 0);
    stallCfg    = (mode == 1) ? 3 : 0;
    randomReady = (mode >= 2);
    buildFrame(mode, withhold);
    startCount = pixCount;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy after start", busy, 1);
    checkOutput("read one cycle after start", busRead, 1);
    checkOutput("error cleared by start", timeoutErr, 0);
    for (int c = 0; c < 2000 && !seenDone; c++) begin
      @(negedge clk);
      if (done) seenDone = 1'b1;
      else start = (mode >= 3) ? 1'($urandom_range(0, 5) == 0) : 1'b0;
    end
    checkOutput("frame completes", seenDone, 1);
    checkOutput("timeout flag", timeoutErr, expErr);
    checkOutput("pixels out", pixCount - startCount, expErr ? withhold : NPIX);
    checkOutput("pending pixels", pixQ.size(), 0);
    checkOutput("reads left", reqQ.size(), expErr ? NPIX - withhold - 1 : 0);
    start = (mode >= 3);
    @(negedge clk);
    start = 1'b0;
    checkOutput("done single pulse", done, 0);
    checkOutput("busy cleared", busy, 0);
    checkOutput("flag held", timeoutErr, expErr);
    reqQ.delete();
    pixQ.delete();
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  initial begin
    resetN   = 1'b0;
    start    = 1'b0;
    busAck   = 1'b0;
    busData  = '0;
    pixReady = 1'b0;
    #2;
    checkOutput("reset control",
                {busy, done, timeoutErr, busRead, busWrite, busByteEnable, pixValid, pixSop, pixEop}, 0);
    checkOutput("reset address", busAddress, 0);
    checkOutput("reset pixel", {busWriteData, pixData}, 0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    checkOutput("busy after reset", busy, 0);

    for (int f = 0; f < 12; f++) applyStimulus(f);

    // Reset in the middle of a pending read must drop the request immediately.
    stallCfg    = 0;
    randomReady = 0;
    buildFrame(3, -1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("read before reset", busRead, 1);
    #2 resetN = 1'b0;
    #1;
    checkOutput("async reset control",
                {busy, done, timeoutErr, busRead, busByteEnable, pixValid, pixSop, pixEop}, 0);
    checkOutput("async reset address", busAddress, 0);
    checkOutput("async reset pixel", pixData, 0);
    repeat (2) @(negedge clk);
    reqQ.delete();
    pixQ.delete();
    resetN = 1'b1;
    @(negedge clk);
    checkOutput("busy after reset release", {busy, busRead}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
